addsub_cmp_seq: RTL and testbench

Parametrised, multi-cycle signed adder/subtractor with registered overflow and full three-way compare flags. It generalises the team's 4-bit combinational add/sub comparator to any width. It processes CHUNK bits per clock with a start/busy/done handshake, so wide operands need no long ripple path. It sits between operand registers and the ALU flag logic in the classroom datapath.

---
 rtl/addsub_cmp_seq_if.sv | 28 ++
 rtl/addsub_cmp_seq.sv | 125 ++++++++++++
 tb/tb_addsub_cmp_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/addsub_cmp_seq_if.sv
// Operand/result bundle for addsub_cmp_seq: requester drives the
// operands and start, the adder returns the handshake and the flags.
interface addsub_cmp_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             error;
    logic             gt;
    logic             ls;
    logic             eq;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, carry, error, gt, ls, eq
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, carry, error, gt, ls, eq
    );
endinterface

// File: rtl/addsub_cmp_seq.sv
// Multi-cycle signed add/sub with overflow and three-way compare flags.
// CHUNK bits are added per clock; all results update together at done.
module addsub_cmp_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input logic              clk,
    input logic              rst,
    addsub_cmp_seq_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NCHUNK - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             cy_q, cy_d;
    logic             carry_q, carry_d, error_q, error_d;
    logic             gt_q, gt_d, ls_q, ls_d, eq_q, eq_d, done_q, done_d;

    logic [CHUNK-1:0] a_c, b_c;
    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] part;
    logic             cin_msb, ovf, ls_n, eq_n;

    always_comb begin
        a_c  = a_q[idx_q*CHUNK +: CHUNK];
        b_c  = b_q[idx_q*CHUNK +: CHUNK];
        csum = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, cy_q};
        part = res_q;
        part[idx_q*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        // Carry into the chunk's top bit, recovered from its sum bit and operand bits.
        cin_msb = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ csum[CHUNK-1];
        ovf     = cin_msb ^ csum[CHUNK];
        ls_n    = part[WIDTH-1] ^ ovf;
        eq_n    = (part == '0) && !ovf;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cy_d    = cy_q;
        idx_d   = idx_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        error_d = error_q;
        gt_d    = gt_q;
        ls_d    = ls_q;
        eq_d    = eq_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    cy_d    = bus.sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = part;
                cy_d  = csum[CHUNK];
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                    sum_d   = part;
                    carry_d = csum[CHUNK];
                    error_d = ovf;
                    ls_d    = ls_n;
                    eq_d    = eq_n;
                    gt_d    = !ls_n && !eq_n;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cy_q    <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            error_q <= 1'b0;
            gt_q    <= 1'b0;
            ls_q    <= 1'b0;
            eq_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cy_q    <= cy_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            error_q <= error_d;
            gt_q    <= gt_d;
            ls_q    <= ls_d;
            eq_q    <= eq_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
    assign bus.error = error_q;
    assign bus.gt    = gt_q;
    assign bus.ls    = ls_q;
    assign bus.eq    = eq_q;
endmodule

// File: tb/tb_addsub_cmp_seq.sv
// Bench for addsub_cmp_seq (WIDTH=8, CHUNK=2): directed corner cases,
// handshake and reset-abort checks, then random operations vs. an integer model.
module tb_addsub_cmp_seq;
    localparam int W = 8;
    localparam int C = 2;
    localparam int NCH = W / C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [W-1:0] prev_sum   = '0;
    logic [4:0]   prev_flags = '0;

    addsub_cmp_seq_if #(.WIDTH(W)) bus ();

    addsub_cmp_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: true signed result computed with plain integers.
    function automatic void model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] sm, output logic [4:0] fl);
        int sx, sy, t, ux, uy;
        logic c, e;
        sx = $signed(x);
        sy = $signed(y);
        ux = {24'b0, x};
        uy = {24'b0, y};
        t  = s ? sx - sy : sx + sy;
        sm = t[W-1:0];
        c  = s ? (ux >= uy) : ((ux + uy) > 255);
        e  = (t > 127) || (t < -128);
        fl = {c, e, t > 0, t < 0, t == 0};
    endfunction

    function automatic logic [4:0] flags_now();
        return {bus.carry, bus.error, bus.gt, bus.ls, bus.eq};
    endfunction

    task automatic idle(input int n);
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_done", bus.done, 1'b0);
            check("idle_hold_sum", bus.sum, prev_sum);
            check("idle_hold_flags", flags_now(), prev_flags);
        end
    endtask

    // Entered and left at a negedge; returns in the done cycle so the next
    // call can issue start there.
    task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit inject, input bit abort);
        logic [W-1:0] es;
        logic [4:0]   ef;
        int lat, bcnt;
        bit got;
        model(s, x, y, es, ef);
        bus.start = 1'b1;
        bus.sub   = s;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.sub   = 1'($urandom);
        got = 0; lat = 0; bcnt = 0;
        for (int j = 0; j < 20 && !got; j++) begin
            if (bus.done) begin
                got = 1;
                lat = j;
            end else begin
                if (bus.busy) bcnt++;
                check("run_hold_sum", bus.sum, prev_sum);
                check("run_hold_flags", flags_now(), prev_flags);
                bus.start = inject && (j == 1);
                if (inject && j == 1) begin
                    bus.sub = ~s;
                    bus.a   = ~x;
                    bus.b   = y + 8'h11;
                end
                if (abort && j == 2) begin
                    bus.start = 1'b0;
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check("abort_busy", bus.busy, 1'b0);
                    check("abort_sum", bus.sum, '0);
                    check("abort_flags", flags_now(), 5'b0);
                    check("abort_done", bus.done, 1'b0);
                    prev_sum = '0;
                    prev_flags = '0;
                    for (int k = 0; k < 8; k++) begin
                        @(negedge clk);
                        check("abort_no_done", bus.done, 1'b0);
                        check("abort_no_busy", bus.busy, 1'b0);
                    end
                    return;
                end
                @(negedge clk);
            end
        end
        check("done_seen", got, 1);
        check("latency", lat, NCH);
        check("busy_cycles", bcnt, NCH);
        check("done_busy_low", bus.busy, 1'b0);
        check("sum", bus.sum, es);
        check("carry", bus.carry, ef[4]);
        check("error", bus.error, ef[3]);
        check("gt", bus.gt, ef[2]);
        check("ls", bus.ls, ef[1]);
        check("eq", bus.eq, ef[0]);
        check("onehot", 32'(bus.gt) + 32'(bus.ls) + 32'(bus.eq), 1);
        prev_sum   = es;
        prev_flags = ef;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_sum", bus.sum, '0);
        check("rst_flags", flags_now(), 5'b0);
        rst = 1'b0;
        idle(2);

        run_op(1'b1, 8'h05, 8'h03, 0, 0);
        idle(1);
        run_op(1'b1, 8'h7F, 8'hFF, 0, 0);
        run_op(1'b1, 8'h80, 8'h01, 0, 0);
        run_op(1'b0, 8'h80, 8'h80, 0, 0);
        run_op(1'b1, 8'h3C, 8'h3C, 0, 0);
        idle(2);

        // Mid-flight start must be ignored; next start lands in the done cycle.
        run_op(1'b1, 8'h50, 8'h20, 1, 0);
        run_op(1'b0, 8'h01, 8'h01, 0, 0);
        idle(1);

        run_op(1'b0, 8'h33, 8'h44, 0, 1);
        run_op(1'b1, 8'h10, 8'h20, 0, 0);

        for (int n = 0; n < 30; n++) begin
            run_op(1'($urandom), W'($urandom), W'($urandom), 0, 0);
            idle(int'($urandom_range(0, 2)));
        end
        run_op(1'b0, 8'h7F, 8'h01, 0, 0);
        run_op(1'b1, 8'h00, 8'h80, 0, 0);
        run_op(1'b0, 8'hFF, 8'h01, 0, 0);
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
